// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS count-up stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t ONES_MAX     = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    // True when the count sits at 59:59, the last representable value.
    function automatic logic is_top(input mmss_t v);
        return (v.min_tens == MIN_TENS_MAX) && (v.min_ones == ONES_MAX) &&
               (v.sec_tens == SEC_TENS_MAX) && (v.sec_ones == ONES_MAX);
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit that counts 0..MAX and reports a carry on the increment that wraps it.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = ONES_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == MAX) ? '0 : q + bcd_t'(1);
        end
    end

    assign carry = inc && (q == MAX);

endmodule

// File: rtl/stopwatch_up_counter.sv
// MM:SS count-up stopwatch with prescaler, run/pause/done FSM and BCD display digits.
// Optional lap (display freeze) feature is compiled in by defining STOPWATCH_LAP_EN.
module stopwatch_up_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int WRAP     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int                PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    state_t             state;
    logic [PRESC_W-1:0] presc;
    bcd_t               d_sec_ones;
    bcd_t               d_sec_tens;
    bcd_t               d_min_ones;
    bcd_t               d_min_tens;
    mmss_t              live;
    mmss_t              shown;
    logic               tick;
    logic               at_top;
    logic               inc_count;
    logic               c_sec_ones;
    logic               c_sec_tens;
    logic               c_min_ones;
    logic               unused_top_carry;

    assign live   = {d_min_tens, d_min_ones, d_sec_tens, d_sec_ones};
    assign tick   = (state == RUN) && (presc == PRESC_LAST);
    assign at_top = is_top(live);

    // A toggle or clear in the tick cycle swallows the increment; saturating builds never step past 59:59.
    assign inc_count = tick && !start_stop && !clear && ((WRAP != 0) || !at_top);

    bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (inc_count),
        .q     (d_sec_ones),
        .carry (c_sec_ones)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (c_sec_ones),
        .q     (d_sec_tens),
        .carry (c_sec_tens)
    );

    bcd_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (c_sec_tens),
        .q     (d_min_ones),
        .carry (c_min_ones)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (c_min_ones),
        .q     (d_min_tens),
        .carry (unused_top_carry)
    );

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            presc    <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_active <= 1'b0;
`endif
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (lap && ((state == RUN) || (state == PAUSE))) begin
                lap_active <= !lap_active;
            end
`endif
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        presc   <= '0;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        // Pausing freezes the prescaler phase so resume loses no time.
                        state   <= PAUSE;
                        running <= 1'b0;
                        if (tick) begin
                            presc <= '0;
                        end
                    end else if (tick) begin
                        presc <= '0;
                        if (at_top) begin
                            overflow <= 1'b1;
                            if (WRAP == 0) begin
                                state   <= DONE;
                                running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
                                lap_active <= 1'b0;
`endif
                            end
                        end
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    mmss_t hold;

    // Snapshot is taken only on the pulse that engages the lap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hold <= '0;
        end else if (lap && !lap_active && ((state == RUN) || (state == PAUSE))) begin
            hold <= live;
        end
    end

    assign shown = lap_active ? hold : live;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign lap_active = 1'b0;
    assign shown      = live;
`endif

    assign sec_ones = shown.sec_ones;
    assign sec_tens = shown.sec_tens;
    assign min_ones = shown.min_ones;
    assign min_tens = shown.min_tens;

endmodule
